// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx through its i_wr/i_data/o_txe handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [DEPTH_LOG2:0] o_level,
    output logic              o_ovf,
    input  logic              i_ovf_clr,
    input  logic              i_txe,
    output logic              o_tx_wr,
    output logic [DATA_W-1:0] o_tx_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] ONE_CNT   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] ZERO_CNT  = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ACK   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_tx_wr;
    logic [DATA_W-1:0]     r_tx_data;
    state_t                r_state;
    state_t                w_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_evt;
    logic [DEPTH_LOG2:0]   w_count_next;

    // A push while full is dropped even if a pop happens on the same edge.
    assign w_push    = i_wr && (r_count != DEPTH_CNT);
    assign w_ovf_evt = i_wr && (r_count == DEPTH_CNT);

    // Next occupancy from this cycle's push and pop.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + ONE_CNT;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - ONE_CNT;
        end else begin
            w_count_next = r_count;
        end
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= ZERO_CNT;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == DEPTH_CNT);
            r_empty <= (w_count_next == ZERO_CNT);
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: one byte per observed txe low-then-high handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count != ZERO_CNT) && i_txe) begin
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: w_next = S_ACK;
            S_ACK: begin
                if (!i_txe) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next = S_ACK;
                end
            end
            S_DRAIN: begin
                if (i_txe) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The pop coincides with the edge that enters LOAD.
    always_comb begin
        w_pop = 1'b0;
        if ((r_state == S_IDLE) && (w_next == S_LOAD)) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    // Transmit strobe and held data toward uart_tx.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_wr   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_tx_wr <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // Sticky overflow; a same-cycle set beats the clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_ovf = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = i_ovf_clr ^ w_ovf_evt;
    assign o_ovf        = 1'b0;
`endif

    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_count;
    assign o_tx_wr   = r_tx_wr;
    assign o_tx_data = r_tx_data;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO placed directly upstream of `uart_tx`, decoupling the bus-side writer from the serial transmitter. It accepts bytes at up to one per `i_clk`, stores them in order, and feeds `uart_tx` one byte at a time through its `i_wr`/`i_data`/`o_txe` handshake. It reports fill status to the writer and, optionally, a sticky overflow flag.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (default 16). Legal range 1..8.
- `DATA_W`, 8: byte width. Fixed at 8 for `uart_tx`.
- `i_clk` in 1: system clock. Same clock as `uart_tx`.
- `i_rst` in 1: synchronous, active-high reset.
- `i_wr` in 1: writer push strobe. Sampled every `i_clk` rising edge while high.
- `i_data` in 8: byte pushed when `i_wr`=1.
- `o_full` out 1: FIFO holds 2^DEPTH_LOG2 entries.
- `o_empty` out 1: FIFO holds 0 entries.
- `o_level` out DEPTH_LOG2+1: current entry count.
- `o_ovf` out 1: sticky overflow flag (see Configuration).
- `i_ovf_clr` in 1: clears `o_ovf`.
- `i_txe` in 1: connects to `uart_tx.o_txe`. High means the transmit holding register is free.
- `o_tx_wr` out 1: connects to `uart_tx.i_wr`. A one-cycle pulse per byte.
- `o_tx_data` out 8: connects to `uart_tx.i_data`. Valid while `o_tx_wr`=1 and held until the next pop.

## Operation
- Storage is a 2^DEPTH_LOG2 × 8 array.
- Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
- The count register is DEPTH_LOG2+1 bits. `o_full`, `o_empty` and `o_level` are derived from the count register only.
- **Push:** `i_wr`=1 and count < depth (count before any same-cycle pop). Data is stored at the write pointer, the write pointer increments, and count increments.
- **Push while full:** the byte is dropped, and count and pointers are unchanged. This holds even if a pop occurs in the same cycle.
- **Pop:** occurs on the cycle the FSM enters LOAD. The entry at the read pointer is registered into `o_tx_data`, the read pointer increments, and count decrements.
- **Simultaneous push and pop** (not full): count is unchanged and both pointers advance.
- FSM states: IDLE, LOAD, ACK, DRAIN.
  - IDLE → LOAD when count ≠ 0 and `i_txe`=1.
  - LOAD: `o_tx_wr`=1 for exactly this cycle. Always → ACK.
  - ACK: waits for `i_txe`=0, meaning `uart_tx` has taken the byte. → DRAIN on `i_txe`=0.
  - DRAIN: waits for `i_txe`=1. → IDLE on `i_txe`=1.
- The FSM never issues a second `o_tx_wr` until `i_txe` has been observed low and then high. This guarantees one byte per transmitter handshake.

## Timing
- Reset values:
  - `o_full`=0, `o_empty`=1, `o_level`=0.
  - `o_ovf`=0, `o_tx_wr`=0, `o_tx_data`=8'h00.
  - Pointers and count are 0. FSM is in IDLE.
  - Array contents are not reset.
- Reset mid-operation discards all stored bytes and returns the FSM to IDLE on the next edge. A byte already handed to `uart_tx` is not recalled.
- Latency with an empty FIFO and `i_txe`=1:
  - Push on edge N.
  - `o_level`=1 after edge N.
  - LOAD entered at edge N+1, so `o_tx_wr` is high between edges N+1 and N+2 with `o_tx_data` valid.
  - `o_level` returns to 0 after edge N+1.
- Minimum spacing between `o_tx_wr` pulses is 4 cycles (LOAD, ACK, DRAIN, IDLE), plus however long `uart_tx` holds `i_txe` low.
- Status outputs are registered and update on the edge after the push or pop that causes the change.
- Sustained writer rate: one byte per `i_clk` until full.

## Configuration
- **`UART_TX_FIFO_OVF_EN` defined:**
  - `o_ovf` sets on any push attempted while full, and stays set until cleared.
  - `i_ovf_clr`=1 clears it on the next edge.
  - If a clear and an overflowing push occur in the same cycle, set wins.
- **Undefined:** `o_ovf` is tied to 0, `i_ovf_clr` is ignored, and dropped pushes are silent. All other behaviour is identical.

## Test plan
- **Reset values:** hold `i_rst`=1 for 2 cycles, release -> `o_empty`=1, `o_level`=0, `o_tx_wr`=0, `o_tx_data`=8'h00, `o_ovf`=0.
- **Single byte:** push 8'h55 with `i_txe`=1 -> `o_tx_wr` pulses for exactly 1 cycle, 1 cycle after the push edge, with `o_tx_data`=8'h55. `o_level` goes 1 then 0.
- **Fill and overflow:** hold `i_txe`=0 and push 8'h00..8'h10 (17 bytes) -> `o_full`=1 after the 16th push and the 17th byte (8'h10) is dropped. `o_ovf`=1 only with `UART_TX_FIFO_OVF_EN`.
- **Ordering and pacing through `uart_tx` at 8×baud:** drive `i_txe`=1, then drain the 16 bytes against a real `uart_tx` -> the `uart_rx` loopback receives 8'h00..8'h0F in order. Exactly one `o_tx_wr` is issued per `i_txe` low→high cycle.
- **Push while full with same-cycle pop:** at full, push 8'hAA on the LOAD cycle -> 8'hAA is dropped and `o_level`=15 afterwards. In the same cycle, assert `i_ovf_clr` with `UART_TX_FIFO_OVF_EN` -> `o_ovf` stays 1.
- **Reset mid-drain:** with 5 bytes queued and the FSM in ACK, pulse `i_rst` -> `o_level`=0, FSM in IDLE, and no further `o_tx_wr` is issued.
